// File: rtl/id_ex_stage.sv
// id_ex_stage: decode stage with write-back bypass, load-use stall and ID/EX pipeline register
module id_ex_stage #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_id_valid,
  input  logic [31:0] if_id_instr,
  input  logic [31:0] if_id_pc4,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_writeReg,
  input  logic [31:0] wb_writeData,
  input  logic        ex_flush,
  output logic        stall,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_rd1,
  output logic [31:0] id_ex_rd2,
  output logic [31:0] id_ex_imm,
  output logic [31:0] id_ex_pc4,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd,
  output logic        id_ex_RegWrite,
  output logic        id_ex_MemRead,
  output logic        id_ex_MemWrite,
  output logic        id_ex_ALUSrc,
  output logic        id_ex_RegDst,
  output logic        id_ex_Branch,
  output logic [1:0]  id_ex_ALUOp,
  output logic [5:0]  id_ex_funct
);
  logic [5:0]  op;
  logic [31:0] op1, op2;
  logic        r_t, lw_t, sw_t, beq_t, addi_t, uses_rt, bubble;
  assign op      = if_id_instr[31:26];
  assign rf_ra1  = if_id_instr[25:21];
  assign rf_ra2  = if_id_instr[20:16];
  assign r_t     = op == 6'h00;
  assign lw_t    = op == 6'h23;
  assign sw_t    = op == 6'h2B;
  assign beq_t   = op == 6'h04;
  assign addi_t  = op == 6'h08;
  assign uses_rt = r_t || sw_t || beq_t;
  // r0 is hardwired to zero, so it also blocks a bypass of a write aimed at r0
  assign op1 = rf_ra1 == 5'd0 ? 32'd0 :
               (BYPASS_EN && wb_RegWrite && wb_writeReg == rf_ra1) ? wb_writeData : rf_rd1;
  assign op2 = rf_ra2 == 5'd0 ? 32'd0 :
               (BYPASS_EN && wb_RegWrite && wb_writeReg == rf_ra2) ? wb_writeData : rf_rd2;
  // a flush kills the decode instruction anyway, so it masks the stall
  assign stall = !rst && !ex_flush && if_id_valid && id_ex_valid && id_ex_MemRead &&
                 id_ex_rt != 5'd0 && (id_ex_rt == rf_ra1 || (uses_rt && id_ex_rt == rf_ra2));
  assign bubble = ex_flush || stall || !if_id_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_valid    <= 1'b0;
      id_ex_RegWrite <= 1'b0;
      id_ex_MemRead  <= 1'b0;
      id_ex_MemWrite <= 1'b0;
      id_ex_ALUSrc   <= 1'b0;
      id_ex_RegDst   <= 1'b0;
      id_ex_Branch   <= 1'b0;
      id_ex_ALUOp    <= 2'b00;
      id_ex_rd1      <= '0;
      id_ex_rd2      <= '0;
      id_ex_imm      <= '0;
      id_ex_pc4      <= '0;
      id_ex_rs       <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
      id_ex_funct    <= '0;
    end else begin
      id_ex_valid    <= !bubble;
      id_ex_RegWrite <= !bubble && (r_t || lw_t || addi_t);
      id_ex_MemRead  <= !bubble && lw_t;
      id_ex_MemWrite <= !bubble && sw_t;
      id_ex_ALUSrc   <= !bubble && (lw_t || sw_t || addi_t);
      id_ex_RegDst   <= !bubble && r_t;
      id_ex_Branch   <= !bubble && beq_t;
      id_ex_ALUOp    <= bubble ? 2'b00 : {r_t, beq_t};
      id_ex_rd1      <= op1;
      id_ex_rd2      <= op2;
      id_ex_imm      <= {{16{if_id_instr[15]}}, if_id_instr[15:0]};
      id_ex_pc4      <= if_id_pc4;
      id_ex_rs       <= rf_ra1;
      id_ex_rt       <= rf_ra2;
      id_ex_rd       <= if_id_instr[15:11];
      id_ex_funct    <= if_id_instr[5:0];
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage decode, bypass, hazards, flush and reset
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_id_valid = 1'b0;
  logic [31:0] if_id_instr = '0;
  logic [31:0] if_id_pc4 = '0;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_RegWrite = 1'b0;
  logic [4:0]  wb_writeReg = '0;
  logic [31:0] wb_writeData = '0;
  logic        ex_flush = 1'b0;
  logic        stall, id_ex_valid;
  logic [31:0] id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic        id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_ALUSrc, id_ex_RegDst, id_ex_Branch;
  logic [1:0]  id_ex_ALUOp;
  logic [5:0]  id_ex_funct;

  id_ex_stage #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_RegWrite(wb_RegWrite), .wb_writeReg(wb_writeReg), .wb_writeData(wb_writeData),
    .ex_flush(ex_flush), .stall(stall), .id_ex_valid(id_ex_valid),
    .id_ex_rd1(id_ex_rd1), .id_ex_rd2(id_ex_rd2), .id_ex_imm(id_ex_imm), .id_ex_pc4(id_ex_pc4),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_RegWrite(id_ex_RegWrite), .id_ex_MemRead(id_ex_MemRead), .id_ex_MemWrite(id_ex_MemWrite),
    .id_ex_ALUSrc(id_ex_ALUSrc), .id_ex_RegDst(id_ex_RegDst), .id_ex_Branch(id_ex_Branch),
    .id_ex_ALUOp(id_ex_ALUOp), .id_ex_funct(id_ex_funct)
  );

  always #5 clk = ~clk;

  // register file model; r0 deliberately returns garbage so the stage must force zero
  logic [31:0] regs [32];
  assign rf_rd1 = regs[rf_ra1];
  assign rf_rd2 = regs[rf_ra2];

  typedef struct packed {
    logic        v;
    logic [7:0]  c;
    logic [31:0] a, b, imm, p;
  } exp_t;
  exp_t q[$];
  int n = 0;
  int fails = 0;
  logic [31:0] cur_pc = 32'h400;

  // {RegWrite, MemRead, MemWrite, ALUSrc, RegDst, Branch, ALUOp}
  logic [7:0] act_c;
  assign act_c = {id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_ALUSrc,
                  id_ex_RegDst, id_ex_Branch, id_ex_ALUOp};
  localparam logic [7:0] C_R = 8'b1000_1010;
  localparam logic [7:0] C_LW = 8'b1101_0000;
  localparam logic [7:0] C_SW = 8'b0011_0000;
  localparam logic [7:0] C_BEQ = 8'b0000_0101;
  localparam logic [7:0] C_ADDI = 8'b1001_0000;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic exp_t mk(input logic v, input logic [7:0] c, input logic [31:0] a, b, imm);
    return '{v: v, c: c, a: a, b: b, imm: imm, p: 32'd0};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic fl);
    @(negedge clk);
    if_id_instr = ins;
    if_id_valid = v;
    ex_flush = fl;
    cur_pc = cur_pc + 32'd4;
    if_id_pc4 = cur_pc;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if_id_valid = 1'b1;
    if_id_instr = itype(6'h23, 5'd3, 5'd2, 16'h0004);
    repeat (2) @(posedge clk);
    #1;
    n++; if ({id_ex_valid, act_c} !== 9'd0) begin fails++; $display("FAIL reset_ctrl got %b want 0", {id_ex_valid, act_c}); end
    n++; if ({id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4} !== 128'd0) begin fails++; $display("FAIL reset_data got %h want 0", {id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4}); end
    n++; if ({id_ex_rs, id_ex_rt, id_ex_rd, id_ex_funct} !== 21'd0) begin fails++; $display("FAIL reset_fields got %h want 0", {id_ex_rs, id_ex_rt, id_ex_rd, id_ex_funct}); end
    n++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    @(negedge clk);
    rst = 1'b0;
    if_id_valid = 1'b0;
  endtask

  task automatic test_bypass;
    logic [31:0] ins [4];
    logic        wre [4];
    logic [4:0]  wrg [4];
    logic [31:0] wdt [4];
    exp_t        ex [4];
    exp_t        e;
    ins = '{rtype(5'd5, 5'd0, 5'd1, 6'h20), rtype(5'd0, 5'd5, 5'd1, 6'h22),
            rtype(5'd5, 5'd6, 5'd7, 6'h2A), rtype(5'd6, 5'd5, 5'd7, 6'h20)};
    wre = '{1'b1, 1'b1, 1'b0, 1'b1};
    wrg = '{5'd5, 5'd0, 5'd5, 5'd5};
    wdt = '{32'h1234, 32'h55, 32'h99, 32'h77};
    ex = '{mk(1'b1, C_R, 32'h1234, 32'h0, 32'h820), mk(1'b1, C_R, 32'h0, 32'h1005, 32'h822),
           mk(1'b1, C_R, 32'h1005, 32'h1006, 32'h382A), mk(1'b1, C_R, 32'h1006, 32'h77, 32'h3820)};
    for (int i = 0; i < 4; i++) begin
      wb_RegWrite = wre[i];
      wb_writeReg = wrg[i];
      wb_writeData = wdt[i];
      drive(ins[i], 1'b1, 1'b0);
      ex[i].p = cur_pc;
      q.push_back(ex[i]);
      n++; if (stall !== 1'b0) begin fails++; $display("FAIL bypass_stall[%0d] got %b want 0", i, stall); end
      @(posedge clk);
      #1;
      e = q.pop_front();
      n++; if ({id_ex_valid, act_c} !== {e.v, e.c}) begin fails++; $display("FAIL bypass_ctrl[%0d] got %b want %b", i, {id_ex_valid, act_c}, {e.v, e.c}); end
      if (e.v) begin
        n++; if ({id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4} !== {e.a, e.b, e.imm, e.p}) begin fails++; $display("FAIL bypass_data[%0d] got %h want %h", i, {id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4}, {e.a, e.b, e.imm, e.p}); end
      end
    end
    n++; if ({id_ex_rs, id_ex_rt, id_ex_rd, id_ex_funct} !== {5'd6, 5'd5, 5'd7, 6'h20}) begin fails++; $display("FAIL bypass_fields got %h want %h", {id_ex_rs, id_ex_rt, id_ex_rd, id_ex_funct}, {5'd6, 5'd5, 5'd7, 6'h20}); end
    wb_RegWrite = 1'b0;
  endtask

  task automatic test_load_use;
    logic [31:0] ins [15];
    logic        vl [15];
    logic        st [15];
    exp_t        ex [15];
    exp_t        e;
    ins = '{itype(6'h23, 5'd3, 5'd2, 16'h0), rtype(5'd2, 5'd1, 5'd4, 6'h20), rtype(5'd2, 5'd1, 5'd4, 6'h20),
            itype(6'h23, 5'd3, 5'd2, 16'h8), itype(6'h08, 5'd5, 5'd2, 16'h1), itype(6'h23, 5'd1, 5'd3, 16'h0),
            itype(6'h2B, 5'd5, 5'd3, 16'h4), itype(6'h2B, 5'd5, 5'd3, 16'h4), itype(6'h04, 5'd1, 5'd2, 16'hFFFF),
            itype(6'h23, 5'd3, 5'd2, 16'h0), rtype(5'd2, 5'd1, 5'd4, 6'h20), itype(6'h23, 5'd3, 5'd2, 16'h0),
            rtype(5'd2, 5'd1, 5'd4, 6'h20), itype(6'h23, 5'd3, 5'd0, 16'h0), rtype(5'd0, 5'd0, 5'd4, 6'h20)};
    vl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    st = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ex = '{mk(1'b1, C_LW, 32'h1003, 32'h1002, 32'h0), mk(1'b0, 8'h0, 32'h0, 32'h0, 32'h0),
           mk(1'b1, C_R, 32'h1002, 32'h1001, 32'h2020), mk(1'b1, C_LW, 32'h1003, 32'h1002, 32'h8),
           mk(1'b1, C_ADDI, 32'h1005, 32'h1002, 32'h1), mk(1'b1, C_LW, 32'h1001, 32'h1003, 32'h0),
           mk(1'b0, 8'h0, 32'h0, 32'h0, 32'h0), mk(1'b1, C_SW, 32'h1005, 32'h1003, 32'h4),
           mk(1'b1, C_BEQ, 32'h1001, 32'h1002, 32'hFFFFFFFF), mk(1'b1, C_LW, 32'h1003, 32'h1002, 32'h0),
           mk(1'b0, 8'h0, 32'h0, 32'h0, 32'h0), mk(1'b0, 8'h0, 32'h0, 32'h0, 32'h0),
           mk(1'b1, C_R, 32'h1002, 32'h1001, 32'h2020), mk(1'b1, C_LW, 32'h1003, 32'h0, 32'h0),
           mk(1'b1, C_R, 32'h0, 32'h0, 32'h2020)};
    for (int i = 0; i < 15; i++) begin
      drive(ins[i], vl[i], 1'b0);
      ex[i].p = cur_pc;
      q.push_back(ex[i]);
      n++; if (stall !== st[i]) begin fails++; $display("FAIL load_use_stall[%0d] got %b want %b", i, stall, st[i]); end
      @(posedge clk);
      #1;
      e = q.pop_front();
      n++; if ({id_ex_valid, act_c} !== {e.v, e.c}) begin fails++; $display("FAIL load_use_ctrl[%0d] got %b want %b", i, {id_ex_valid, act_c}, {e.v, e.c}); end
      if (e.v) begin
        n++; if ({id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4} !== {e.a, e.b, e.imm, e.p}) begin fails++; $display("FAIL load_use_data[%0d] got %h want %h", i, {id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4}, {e.a, e.b, e.imm, e.p}); end
      end
    end
  endtask

  task automatic test_flush;
    logic [31:0] ins [4];
    logic        fl [4];
    exp_t        ex [4];
    exp_t        e;
    ins = '{itype(6'h23, 5'd3, 5'd2, 16'h0), rtype(5'd2, 5'd1, 5'd4, 6'h20),
            rtype(5'd2, 5'd1, 5'd4, 6'h20), itype(6'h08, 5'd0, 5'd1, 16'h5)};
    fl = '{1'b0, 1'b1, 1'b0, 1'b1};
    ex = '{mk(1'b1, C_LW, 32'h1003, 32'h1002, 32'h0), mk(1'b0, 8'h0, 32'h0, 32'h0, 32'h0),
           mk(1'b1, C_R, 32'h1002, 32'h1001, 32'h2020), mk(1'b0, 8'h0, 32'h0, 32'h0, 32'h0)};
    for (int i = 0; i < 4; i++) begin
      drive(ins[i], 1'b1, fl[i]);
      ex[i].p = cur_pc;
      q.push_back(ex[i]);
      n++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall[%0d] got %b want 0", i, stall); end
      @(posedge clk);
      #1;
      e = q.pop_front();
      n++; if ({id_ex_valid, act_c} !== {e.v, e.c}) begin fails++; $display("FAIL flush_ctrl[%0d] got %b want %b", i, {id_ex_valid, act_c}, {e.v, e.c}); end
      if (e.v) begin
        n++; if ({id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4} !== {e.a, e.b, e.imm, e.p}) begin fails++; $display("FAIL flush_data[%0d] got %h want %h", i, {id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4}, {e.a, e.b, e.imm, e.p}); end
      end
    end
    ex_flush = 1'b0;
  endtask

  task automatic test_imm;
    logic [31:0] ins [3];
    logic        vl [3];
    exp_t        ex [3];
    exp_t        e;
    ins = '{itype(6'h08, 5'd0, 5'd1, 16'h8000), itype(6'h3F, 5'd1, 5'd2, 16'h7FFF), itype(6'h23, 5'd3, 5'd2, 16'h0)};
    vl = '{1'b1, 1'b1, 1'b0};
    ex = '{mk(1'b1, C_ADDI, 32'h0, 32'h1001, 32'hFFFF8000), mk(1'b1, 8'h0, 32'h1001, 32'h1002, 32'h7FFF),
           mk(1'b0, 8'h0, 32'h0, 32'h0, 32'h0)};
    for (int i = 0; i < 3; i++) begin
      drive(ins[i], vl[i], 1'b0);
      ex[i].p = cur_pc;
      q.push_back(ex[i]);
      n++; if (stall !== 1'b0) begin fails++; $display("FAIL imm_stall[%0d] got %b want 0", i, stall); end
      @(posedge clk);
      #1;
      e = q.pop_front();
      n++; if ({id_ex_valid, act_c} !== {e.v, e.c}) begin fails++; $display("FAIL imm_ctrl[%0d] got %b want %b", i, {id_ex_valid, act_c}, {e.v, e.c}); end
      if (e.v) begin
        n++; if ({id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4} !== {e.a, e.b, e.imm, e.p}) begin fails++; $display("FAIL imm_data[%0d] got %h want %h", i, {id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4}, {e.a, e.b, e.imm, e.p}); end
      end
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    drive(itype(6'h23, 5'd3, 5'd2, 16'h0), 1'b1, 1'b0);
    @(posedge clk);
    drive(rtype(5'd2, 5'd1, 5'd4, 6'h20), 1'b1, 1'b0);
    n++; if (stall !== 1'b1) begin fails++; $display("FAIL areset_pre_stall got %b want 1", stall); end
    #2 rst = 1'b1;
    #1;
    n++; if ({id_ex_valid, act_c} !== 9'd0) begin fails++; $display("FAIL areset_ctrl got %b want 0", {id_ex_valid, act_c}); end
    n++; if ({id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_funct} !== 149'd0) begin fails++; $display("FAIL areset_data got %h want 0", {id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4}); end
    n++; if (stall !== 1'b0) begin fails++; $display("FAIL areset_stall got %b want 0", stall); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n++; if ({id_ex_valid, stall} !== 2'b00) begin fails++; $display("FAIL areset_release got %b want 00", {id_ex_valid, stall}); end
    q.push_back('{v: 1'b1, c: C_R, a: 32'h1002, b: 32'h1001, imm: 32'h2020, p: cur_pc});
    @(posedge clk);
    #1;
    e = q.pop_front();
    n++; if ({id_ex_valid, act_c} !== {e.v, e.c}) begin fails++; $display("FAIL areset_first_ctrl got %b want %b", {id_ex_valid, act_c}, {e.v, e.c}); end
    n++; if ({id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4} !== {e.a, e.b, e.imm, e.p}) begin fails++; $display("FAIL areset_first_data got %h want %h", {id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_pc4}, {e.a, e.b, e.imm, e.p}); end
  endtask

  initial begin
    regs[0] = 32'hDEADBEEF;
    for (int i = 1; i < 32; i++) regs[i] = 32'h1000 + i;
    test_reset;
    test_bypass;
    test_load_use;
    test_flush;
    test_imm;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
